// File: rtl/layer_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_serializer
//  Purpose  : Captures the parallel outputs of one fully-connected layer in a
//             single cycle, then replays them one per clock, in neuron-index
//             order, as the x_valid/x_in stream for the next layer.
//             The optional argmax tracker is enabled by defining the macro
//             LAYER_SER_ARGMAX_EN. It reports the index of the frame's
//             largest signed element.
//  Ports    : clk        - sole clock, rising edge
//             rst        - asynchronous, active-low reset
//             in_valid   - upstream per-neuron valid; bit 0 is the frame strobe
//             in_data    - upstream outputs; neuron i at [i*dataWidth +: dataWidth]
//             x_valid    - serial element valid
//             x_out      - serial element
//             busy       - high while a frame is being replayed
//             overrun    - sticky: a frame strobe arrived mid-frame and was dropped
//             max_idx    - argmax index of the last completed frame (argmax build)
//             max_valid  - one-cycle pulse when max_idx updates (argmax build)
//  Revision : 1.0 - initial release
// ============================================================================
module layer_serializer #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             in_valid,
    input  logic [NN*dataWidth-1:0]   in_data,
    output logic                      x_valid,
    output logic [dataWidth-1:0]      x_out,
    output logic                      busy,
    output logic                      overrun
`ifdef LAYER_SER_ARGMAX_EN
    ,
    output logic [$clog2(NN)-1:0]     max_idx,
    output logic                      max_valid
`endif
);

    localparam int            CW     = $clog2(NN);
    localparam logic [CW-1:0] C_LAST = CW'(NN - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [dataWidth-1:0]   r_buf [NN];
    logic                   r_overrun;

    logic                   w_strobe;
    logic                   w_at_last;
    logic                   w_capture;
    logic [dataWidth-1:0]   w_elem;
    logic                   w_unused_valid;

    // Upstream neurons raise valid together, so only bit 0 carries information.
    assign w_unused_valid = ^in_valid[NN-1:1];
    assign w_strobe       = in_valid[0];
    assign w_at_last      = (r_cnt == C_LAST);
    // A new frame may land on the last element cycle, which makes frames gapless.
    assign w_capture      = w_strobe && ((r_state == IDLE) || w_at_last);
    assign w_elem         = r_buf[r_cnt];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NN; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_capture) begin
                for (int i = 0; i < NN; i++) begin
                    r_buf[i] <= in_data[i*dataWidth +: dataWidth];
                end
                r_cnt   <= '0;
                r_state <= SHIFT;
            end else if (r_state == SHIFT) begin
                if (w_at_last) begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            // A strobe mid-frame is dropped; the running frame is left untouched.
            if (w_strobe && (r_state == SHIFT) && !w_at_last) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign x_valid = (r_state == SHIFT);
    assign busy    = (r_state == SHIFT);
    assign x_out   = (r_state == SHIFT) ? w_elem : '0;
    assign overrun = r_overrun;

`ifdef LAYER_SER_ARGMAX_EN
    logic signed [dataWidth-1:0] r_run_max;
    logic [CW-1:0]               r_run_idx;
    logic                        w_greater;
    logic [CW-1:0]               w_final_idx;

    // Strictly greater only, so ties keep the lower index.
    assign w_greater   = ($signed(w_elem) > r_run_max);
    // The final element has to be folded in on the same edge that publishes.
    assign w_final_idx = ((r_cnt != '0) && w_greater) ? r_cnt : r_run_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_max <= '0;
            r_run_idx <= '0;
            max_idx   <= '0;
            max_valid <= 1'b0;
        end else begin
            max_valid <= 1'b0;
            if (r_state == SHIFT) begin
                if (r_cnt == '0) begin
                    r_run_max <= $signed(w_elem);
                    r_run_idx <= '0;
                end else if (w_greater) begin
                    r_run_max <= $signed(w_elem);
                    r_run_idx <= r_cnt;
                end
                if (w_at_last) begin
                    max_idx   <= w_final_idx;
                    max_valid <= 1'b1;
                end
            end
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_serializer
//  Purpose  : Directed self-checking bench for layer_serializer with NN=4,
//             dataWidth=16. Argmax checks are compiled in only when
//             LAYER_SER_ARGMAX_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_serializer;

    localparam int NN = 4;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [NN-1:0]     in_valid;
    logic [NN*DW-1:0]  in_data;
    logic              x_valid;
    logic [DW-1:0]     x_out;
    logic              busy;
    logic              overrun;
`ifdef LAYER_SER_ARGMAX_EN
    logic [1:0]        max_idx;
    logic              max_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    layer_serializer #(.NN(NN), .dataWidth(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .x_valid  (x_valid),
        .x_out    (x_out),
        .busy     (busy),
        .overrun  (overrun)
`ifdef LAYER_SER_ARGMAX_EN
        ,
        .max_idx  (max_idx),
        .max_valid(max_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        tick();
        tick();

        // Reset state
        check("rst_x_valid", {31'd0, x_valid}, 32'd0);
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_x_out",   {16'd0, x_out},   32'd0);
`ifdef LAYER_SER_ARGMAX_EN
        check("rst_max_idx",   {30'd0, max_idx},   32'd0);
        check("rst_max_valid", {31'd0, max_valid}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        check("idle_x_valid", {31'd0, x_valid}, 32'd0);

        // Single frame: neuron0=1 .. neuron3=4
        in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("single_x_valid", {31'd0, x_valid}, 32'd1);
            check("single_busy",    {31'd0, busy},    32'd1);
            check("single_x_out",   {16'd0, x_out},   i + 1);
            tick();
        end
        check("single_end_x_valid", {31'd0, x_valid}, 32'd0);
        check("single_end_busy",    {31'd0, busy},    32'd0);
        check("single_end_x_out",   {16'd0, x_out},   32'd0);

        // Back-to-back: second strobe on the last element cycle
        in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        for (int i = 0; i < 8; i++) begin
            check("b2b_x_valid", {31'd0, x_valid}, 32'd1);
            check("b2b_x_out",   {16'd0, x_out},   i + 1);
            if (i == 3) begin
                in_data  = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
                in_valid = 4'hF;
            end else begin
                in_valid = 4'h0;
            end
            tick();
        end
        check("b2b_end_x_valid", {31'd0, x_valid}, 32'd0);
        check("b2b_overrun",     {31'd0, overrun}, 32'd0);

        // Overrun: second strobe on the 2nd element cycle
        in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("ovr_x_valid", {31'd0, x_valid}, 32'd1);
            check("ovr_x_out",   {16'd0, x_out},   i + 1);
            if (i == 1) begin
                in_data  = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
                in_valid = 4'hF;
            end else begin
                in_valid = 4'h0;
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("ovr_dropped_x_valid", {31'd0, x_valid}, 32'd0);
            check("ovr_sticky",          {31'd0, overrun}, 32'd1);
            tick();
        end

        // Strobe detection: bit 0 low means no capture
        in_data  = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        in_valid = 4'b1110;
        tick();
        in_valid = 4'h0;
        check("nostrobe_x_valid", {31'd0, x_valid}, 32'd0);
        tick();
        check("nostrobe_busy",    {31'd0, busy},    32'd0);
        check("nostrobe_overrun", {31'd0, overrun}, 32'd1);

        // Mid-frame reset after element 1
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        check("midrst_el0", {16'd0, x_out}, 32'd1);
        tick();
        check("midrst_el1", {16'd0, x_out}, 32'd2);
        rst = 1'b0;
        #1;
        check("midrst_async_x_valid", {31'd0, x_valid}, 32'd0);
        check("midrst_async_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_async_x_out",   {16'd0, x_out},   32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_elems", {31'd0, x_valid}, 32'd0);
            tick();
        end

`ifdef LAYER_SER_ARGMAX_EN
        // Argmax with a tie: {-1, 0x10, 0x10, 0x8000} -> index 1
        in_data  = {16'h8000, 16'h0010, 16'h0010, 16'hFFFF};
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("amax1_no_pulse", {31'd0, max_valid}, 32'd0);
            tick();
        end
        check("amax1_pulse", {31'd0, max_valid}, 32'd1);
        check("amax1_idx",   {30'd0, max_idx},   32'd1);
        tick();
        check("amax1_pulse_end", {31'd0, max_valid}, 32'd0);
        check("amax1_idx_hold",  {30'd0, max_idx},   32'd1);

        // All negative: {0x8000, 0xFFF0, 0xFFFF, 0x9000} -> index 2
        in_data  = {16'h9000, 16'hFFFF, 16'hFFF0, 16'h8000};
        in_valid = 4'hF;
        tick();
        in_valid = 4'h0;
        for (int i = 0; i < 4; i++) begin
            check("amax2_no_pulse", {31'd0, max_valid}, 32'd0);
            tick();
        end
        check("amax2_pulse", {31'd0, max_valid}, 32'd1);
        check("amax2_idx",   {30'd0, max_idx},   32'd2);
        tick();
        check("amax2_pulse_end", {31'd0, max_valid}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_serializer.md
# layer_serializer

Converts the parallel result of one fully-connected layer (NN neuron outputs, each `dataWidth` bits, with per-neuron valid bits) into the serial `x_valid`/`x_in` stream that the next layer's neurons consume, one value per clock. It sits between consecutive layer instances, on the layer-output side. It captures a whole frame in one cycle, then replays it in neuron-index order. An optional argmax tracker reports the winning neuron of the frame, which is used after the final classification layer.

## Interface
- `NN`, 30, neurons in the upstream layer (frame length), ≥2
- `dataWidth`, 16, bits per neuron output, two's-complement fixed point
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  NN  upstream per-neuron valid; only bit 0 is used as the frame strobe
- `in_data`  in  NN*dataWidth  upstream outputs; neuron i at `[i*dataWidth +: dataWidth]`
- `x_valid`  out  1  serial element valid (feeds next layer `x_valid`)
- `x_out`  out  dataWidth  serial element (feeds next layer `x_in`)
- `busy`  out  1  high while a frame is being replayed
- `overrun`  out  1  sticky flag: a frame strobe was dropped
- `max_idx`  out  $clog2(NN)  argmax index (only with `LAYER_SER_ARGMAX_EN`)
- `max_valid`  out  1  one-cycle pulse when `max_idx` is updated (only with `LAYER_SER_ARGMAX_EN`)

## Operation
- Storage: `buf` of NN×dataWidth registers; counter `cnt` of $clog2(NN) bits; state register with states IDLE and SHIFT.
- Capture happens when `in_valid[0]`=1 and either (state=IDLE) or (state=SHIFT and `cnt`=NN-1).
  - On capture: `buf`←`in_data`, `cnt`←0, state←SHIFT.
  - `in_valid[NN-1:1]` are ignored; upstream neurons assert valid simultaneously.
- SHIFT:
  - `x_valid`=1 and `x_out`=`buf[cnt]` (mux on registered state, no extra register).
  - `cnt` increments each cycle.
  - At `cnt`=NN-1: return to IDLE, unless a capture occurs on that same edge, in which case the state stays SHIFT with `cnt`=0 and new data.
- IDLE: `x_valid`=0 and `x_out`=0.
- `busy` = (state=SHIFT).
- Overrun: `in_valid[0]`=1 while state=SHIFT and `cnt`≠NN-1.
  - The strobe is dropped; the current frame continues unchanged.
  - `overrun` is set and stays set until reset.
- `cnt` never wraps past NN-1; a frame is exactly NN elements.
- Reset (any time, including mid-frame) forces these values immediately:
  - state=IDLE, `cnt`=0, `buf`=0.
  - `x_valid`=0, `x_out`=0, `busy`=0, `overrun`=0.
  - `max_idx`=0, `max_valid`=0.
  - The partial frame is discarded.

## Timing
- Capture edge E0 → element i is presented during the cycle following edge E0+i, for i=0..NN-1.
  - Latency is 1 cycle; a frame occupies NN consecutive cycles.
- Frames are gapless when the next strobe coincides with the last element cycle (`cnt`=NN-1).
- Minimum accepted strobe period: NN cycles.
- No backpressure: the downstream side must accept one element per cycle.

## Configuration
- Macro `LAYER_SER_ARGMAX_EN`. When defined:
  - Registers `run_max` (signed dataWidth) and `run_idx` track the frame maximum.
  - On `cnt`=0 they load element 0 unconditionally.
  - On later elements they update only on strictly greater signed value, so ties keep the lower index.
  - On the edge ending the `cnt`=NN-1 cycle, `max_idx`←final index (considering element NN-1) and `max_valid` pulses high for exactly one cycle.
  - `max_idx` holds until the next frame completes.
  - Back-to-back frames restart tracking cleanly at `cnt`=0.
- When not defined: `max_idx` and `max_valid` ports are absent and no compare logic is built; all other behaviour is identical.

## Test plan
- Test plan uses NN=4, dataWidth=16.
- Reset then idle: `x_valid`, `busy`, `overrun` and `x_out` are all 0; asserting `rst`=0 mid-frame (after element 1) → the next cycle has `x_valid`=0 and no further elements.
- Single frame with `in_data`={0x0004,0x0003,0x0002,0x0001} (neuron0=0x0001) and a one-cycle `in_valid`=4'hF → `x_valid` high for 4 cycles starting 1 cycle after the strobe, `x_out`=0x0001,0x0002,0x0003,0x0004, then `x_valid`=0.
- Back-to-back: second strobe exactly on the 4th element cycle with new data {0x0008..0x0005} → 8 contiguous `x_valid` cycles; `overrun` stays 0.
- Overrun: second strobe on the 2nd element cycle → the first frame is output intact, the second is dropped, `overrun`=1 until reset.
- Strobe detection: `in_valid`=4'b1110 (bit 0 low) → no capture and `x_valid` stays 0.
- Argmax (`LAYER_SER_ARGMAX_EN` defined):
  - Frame {0xFFFF(-1), 0x0010, 0x0010, 0x8000} in neuron order 0..3 → `max_idx`=1 and `max_valid` pulses once, right after the last element.
  - Frame of all-negative values {0x8000,0xFFF0,0xFFFF,0x9000} → `max_idx`=2.
